decode_hazard_controller: RTL and testbench

- Owns the IF/ID pipeline register and sequences the decode stage.
- Its registered instruction and PC feed the decode datapath: immediate generation, register-file read and control decode.
- Detects load-use hazards and inserts a one-cycle stall plus an ID/EX bubble.
- Squashes wrong-path instructions on a taken branch or jump redirect from EX, including a configurable fetch-latency shadow, and keeps saturating stall and flush counters.

---
 rtl/decode_hazard_controller_if.sv | 29 ++
 rtl/decode_hazard_controller.sv | 89 ++++++++
 tb/tb_decode_hazard_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/decode_hazard_controller_if.sv
// decode_hazard_controller_if: fetch, execute-feedback and decode-side signals of the decode stage
interface decode_hazard_controller_if #(
    parameter int COUNTER_WIDTH = 16
);
    logic                     fetchValid;
    logic [31:0]              fetchInstruction;
    logic [31:0]              fetchPc;
    logic                     exValid;
    logic                     exMemRead;
    logic [4:0]               exRd;
    logic                     redirectValid;
    logic [31:0]              decodeInstruction;
    logic [31:0]              decodePc;
    logic                     decodeValid;
    logic                     pcStall;
    logic                     idExBubble;
    logic [COUNTER_WIDTH-1:0] stallCount;
    logic [COUNTER_WIDTH-1:0] flushCount;

    modport master (
        output fetchValid, fetchInstruction, fetchPc, exValid, exMemRead, exRd, redirectValid,
        input  decodeInstruction, decodePc, decodeValid, pcStall, idExBubble, stallCount, flushCount
    );

    modport slave (
        input  fetchValid, fetchInstruction, fetchPc, exValid, exMemRead, exRd, redirectValid,
        output decodeInstruction, decodePc, decodeValid, pcStall, idExBubble, stallCount, flushCount
    );
endinterface

// File: rtl/decode_hazard_controller.sv
// decode_hazard_controller: IF/ID register with load-use stall, redirect squash/shadow and event counters
module decode_hazard_controller #(
    parameter int REDIRECT_SHADOW = 0,
    parameter int COUNTER_WIDTH   = 16
) (
    input logic                       clk,
    input logic                       resetN,
    decode_hazard_controller_if.slave bus
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [2:0]  SHADOW_LEN = 3'(REDIRECT_SHADOW);

    typedef enum logic [1:0] {RUN, STALL, SHADOW} state_t;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, hazard;
    logic       hold, squash;

    assign op       = bus.decodeInstruction[6:0];
    assign rs1      = bus.decodeInstruction[19:15];
    assign rs2      = bus.decodeInstruction[24:20];
    assign uses_rs1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    assign uses_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign hazard   = bus.decodeValid & bus.exValid & bus.exMemRead & (bus.exRd != 5'd0) &
                      ((uses_rs1 & (rs1 == bus.exRd)) | (uses_rs2 & (rs2 == bus.exRd)));

    assign bus.pcStall    = hold;
    assign bus.idExBubble = hold | bus.redirectValid;

    // Next state: redirect beats everything, STALL never re-checks the hazard, SHADOW counts down
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold    = 1'b0;
        squash  = 1'b0;
        if (bus.redirectValid) begin
            squash  = 1'b1;
            cnt_n   = SHADOW_LEN;
            state_n = (REDIRECT_SHADOW > 0) ? SHADOW : RUN;
        end else if (state == SHADOW) begin
            squash  = 1'b1;
            cnt_n   = cnt - 3'd1;
            state_n = (cnt == 3'd1) ? RUN : SHADOW;
        end else if (state == STALL) begin
            state_n = RUN;
        end else if (hazard) begin
            hold    = 1'b1;
            state_n = STALL;
        end
    end

    // Sequencer state and shadow countdown
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // IF/ID register: holds on stall, takes a NOP when squashed or when fetch is empty
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.decodeInstruction <= NOP;
            bus.decodePc          <= 32'd0;
            bus.decodeValid       <= 1'b0;
        end else if (!hold) begin
            bus.decodeInstruction <= (squash || !bus.fetchValid) ? NOP : bus.fetchInstruction;
            bus.decodePc          <= squash ? 32'd0 : bus.fetchPc;
            bus.decodeValid       <= bus.fetchValid & ~squash;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.stallCount <= '0;
            bus.flushCount <= '0;
        end else begin
            if (hold && !(&bus.stallCount)) bus.stallCount <= bus.stallCount + 1'b1;
            if (bus.redirectValid && !(&bus.flushCount)) bus.flushCount <= bus.flushCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_hazard_controller.sv
// tb_decode_hazard_controller: directed scoreboard bench for the decode hazard controller
module tb_decode_hazard_controller;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD0 = 32'h0020_8133;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] Y    = 32'h0041_8233;
    localparam logic [31:0] LUI  = 32'h0000_10B7;
    localparam logic [31:0] LW   = 32'h0000_A103;
    localparam logic [31:0] X    = 32'h0010_0113;
    localparam logic [31:0] T    = 32'h0030_0193;
    localparam logic [31:0] Z    = 32'h00C0_0293;
    localparam logic [31:0] W    = 32'h0070_0313;

    typedef struct {
        logic [31:0] i;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic rst2 = 1'b0;
    int compared = 0;
    int mismatched = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    decode_hazard_controller_if #(.COUNTER_WIDTH(16)) bus ();
    decode_hazard_controller_if #(.COUNTER_WIDTH(2))  sbus ();

    decode_hazard_controller #(.REDIRECT_SHADOW(2), .COUNTER_WIDTH(16)) dut (
        .clk(clk), .resetN(resetN), .bus(bus.slave)
    );

    decode_hazard_controller #(.REDIRECT_SHADOW(0), .COUNTER_WIDTH(2)) sat (
        .clk(clk), .resetN(rst2), .bus(sbus.slave)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] pc);
        q.push_back('{i, pc});
    endtask

    task automatic cyc(input logic fv, input logic [31:0] fi, input logic [31:0] fp,
                       input logic exv, input logic exm, input logic [4:0] rd, input logic rv,
                       input logic es, input logic eb);
        bus.fetchValid       = fv;
        bus.fetchInstruction = fi;
        bus.fetchPc          = fp;
        bus.exValid          = exv;
        bus.exMemRead        = exm;
        bus.exRd             = rd;
        bus.redirectValid    = rv;
        #3;
        chk("pcStall", 32'(bus.pcStall), 32'(es));
        chk("idExBubble", 32'(bus.idExBubble), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.decodeValid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_decode: got %h at pc %h expected no valid entry",
                         bus.decodeInstruction, bus.decodePc);
            end else begin
                e = q.pop_front();
                chk("decode_instr", bus.decodeInstruction, e.i);
                chk("decode_pc", bus.decodePc, e.pc);
            end
        end
    end

    initial begin
        bus.fetchValid = 0; bus.fetchInstruction = 0; bus.fetchPc = 0;
        bus.exValid = 0; bus.exMemRead = 0; bus.exRd = 0; bus.redirectValid = 0;
        sbus.fetchValid = 0; sbus.fetchInstruction = 0; sbus.fetchPc = 0;
        sbus.exValid = 0; sbus.exMemRead = 0; sbus.exRd = 0; sbus.redirectValid = 0;
        #12;
        chk("rst_instr", bus.decodeInstruction, NOP);
        chk("rst_pc", bus.decodePc, 32'd0);
        chk("rst_valid", 32'(bus.decodeValid), 32'd0);
        chk("rst_pcStall", 32'(bus.pcStall), 32'd0);
        chk("rst_bubble", 32'(bus.idExBubble), 32'd0);
        chk("rst_stallCount", 32'(bus.stallCount), 32'd0);
        chk("rst_flushCount", 32'(bus.flushCount), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        rst2   = 1'b1;

        cyc(1, ADDI, 32'h0, 0, 0, 0, 0, 0, 0); push(ADDI, 32'h0);
        cyc(1, ADD0, 32'h4, 0, 0, 0, 0, 0, 0); push(ADD0, 32'h4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("normal_stallCount", 32'(bus.stallCount), 32'd0);
        chk("normal_flushCount", 32'(bus.flushCount), 32'd0);

        cyc(1, ADD, 32'h8, 0, 0, 0, 0, 0, 0); push(ADD, 32'h8);
        cyc(1, Y, 32'hC, 1, 1, 1, 0, 1, 1);   push(ADD, 32'h8);
        cyc(1, Y, 32'hC, 1, 1, 1, 0, 0, 0);   push(Y, 32'hC);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("loaduse_stallCount", 32'(bus.stallCount), 32'd1);

        cyc(1, LUI, 32'h10, 0, 0, 0, 0, 0, 0); push(LUI, 32'h10);
        cyc(1, LUI, 32'h14, 1, 1, 0, 0, 0, 0); push(LUI, 32'h14);
        cyc(1, LUI, 32'h18, 1, 1, 1, 0, 0, 0); push(LUI, 32'h18);
        cyc(1, LW, 32'h1C, 1, 1, 2, 0, 0, 0);  push(LW, 32'h1C);
        cyc(1, ADDI, 32'h20, 1, 1, 0, 0, 0, 0); push(ADDI, 32'h20);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("nofalse_stallCount", 32'(bus.stallCount), 32'd1);

        cyc(1, X, 32'h24, 0, 0, 0, 1, 0, 1);
        cyc(1, X, 32'h28, 0, 0, 0, 0, 0, 0);
        cyc(1, X, 32'h2C, 0, 0, 0, 0, 0, 0);
        cyc(1, T, 32'h40, 0, 0, 0, 0, 0, 0); push(T, 32'h40);
        chk("redirect_flushCount", 32'(bus.flushCount), 32'd1);

        cyc(1, ADD, 32'h44, 0, 0, 0, 0, 0, 0); push(ADD, 32'h44);
        cyc(1, Y, 32'h48, 1, 1, 1, 0, 1, 1);   push(ADD, 32'h44);
        cyc(1, Y, 32'h48, 1, 1, 1, 1, 0, 1);
        cyc(1, Y, 32'h4C, 0, 0, 0, 0, 0, 0);
        cyc(1, Y, 32'h50, 0, 0, 0, 1, 0, 1);
        cyc(1, Y, 32'h54, 0, 0, 0, 0, 0, 0);
        cyc(1, Y, 32'h58, 0, 0, 0, 0, 0, 0);
        cyc(1, Z, 32'h80, 0, 0, 0, 0, 0, 0);   push(Z, 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stallredir_flushCount", 32'(bus.flushCount), 32'd3);
        chk("stallredir_stallCount", 32'(bus.stallCount), 32'd2);

        cyc(1, X, 32'h90, 0, 0, 0, 1, 0, 1);
        bus.redirectValid = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("midrst_instr", bus.decodeInstruction, NOP);
        chk("midrst_pc", bus.decodePc, 32'd0);
        chk("midrst_valid", 32'(bus.decodeValid), 32'd0);
        chk("midrst_pcStall", 32'(bus.pcStall), 32'd0);
        chk("midrst_bubble", 32'(bus.idExBubble), 32'd0);
        chk("midrst_stallCount", 32'(bus.stallCount), 32'd0);
        chk("midrst_flushCount", 32'(bus.flushCount), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc(1, W, 32'h100, 0, 0, 0, 0, 0, 0); push(W, 32'h100);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        sbus.fetchValid       = 1'b1;
        sbus.fetchInstruction = ADD;
        sbus.fetchPc          = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            sbus.exValid = 1; sbus.exMemRead = 1; sbus.exRd = 5'd1;
            #3;
            chk("sat_pcStall", 32'(sbus.pcStall), 32'd1);
            @(posedge clk);
            #1;
            sbus.exValid = 0; sbus.exMemRead = 0; sbus.exRd = 5'd0;
            @(posedge clk);
            #1;
        end
        chk("sat_stallCount", 32'(sbus.stallCount), 32'd3);
        for (int i = 0; i < 4; i++) begin
            sbus.redirectValid = 1'b1;
            #3;
            chk("sat_bubble", 32'(sbus.idExBubble), 32'd1);
            @(posedge clk);
            #1;
            sbus.redirectValid = 1'b0;
        end
        chk("sat_flushCount", 32'(sbus.flushCount), 32'd3);
        chk("noshadow_squashed", 32'(sbus.decodeValid), 32'd0);
        @(posedge clk);
        #1;
        chk("noshadow_resume", 32'(sbus.decodeValid), 32'd1);
        chk("noshadow_instr", sbus.decodeInstruction, ADD);

        @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
